// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX transmit arbiter slice.
// Holds the FSM state enum, field widths and parameter defaults.
package fix_pkg;

    localparam int ID_W        = 2;
    localparam int LEN_W       = 16;
    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == '1) ? v : v + LEN_W'(1);
    endfunction

endpackage

// File: rtl/fix_rr_arbiter.sv
// Combinational round-robin selector: the search starts one past the
// previous winner and wraps, returning a one-hot grant.
module fix_rr_arbiter
    import fix_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // NOTE: every variable written here gets a default first, so no path infers a latch.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = IDX_W'((int'(last_i) + off) % NUM_REQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fix_tx_arbiter.sv
// Message-granular arbiter that lets several FIX session engines share one
// TOE transmit FIFO, with idle timeout, length count and overflow flag.
module fix_tx_arbiter
    import fix_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ-1:0]      fifo_write_i,
    input  logic [8*NUM_REQ-1:0]    message_i,
    input  logic [NUM_REQ-1:0]      end_i,
    input  logic [ID_W*NUM_REQ-1:0] id_i,
    input  logic                    fifo_full_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [NUM_REQ-1:0]      fifo_full_o,
    output logic                    fifo_write_o,
    output logic [7:0]              message_o,
    output logic                    end_o,
    output logic [ID_W-1:0]         id_o,
    output logic [LEN_W-1:0]        msg_len_o,
    output logic                    abort_o,
    output logic                    overflow_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               wr_q, wr_d;
    logic [7:0]         msg_q, msg_d;
    logic               end_q, end_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [TO_W-1:0]    idle_q, idle_d;
    logic               abort_q, abort_d;
    logic               ovf_q, ovf_d;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [ID_W-1:0]    win_id;
    logic [IDX_W-1:0]   cur_idx;
    logic               g_wr, g_end;
    logic [7:0]         g_byte;

    fix_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i  (req_i),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    // Select the granted requester's inputs with constant indices only.
    always_comb begin
        win_id  = '0;
        cur_idx = '0;
        g_wr    = 1'b0;
        g_end   = 1'b0;
        g_byte  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rr_gnt[k]) win_id = id_i[ID_W*k +: ID_W];
            if (gnt_q[k]) begin
                cur_idx = IDX_W'(k);
                g_wr    = fifo_write_i[k];
                g_end   = end_i[k];
                g_byte  = message_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        id_d    = id_q;
        wr_d    = 1'b0;
        msg_d   = msg_q;
        end_d   = 1'b0;
        cnt_d   = cnt_q;
        len_d   = '0;
        idle_d  = idle_q;
        abort_d = 1'b0;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_XFER;
                    gnt_d   = rr_gnt;
                    id_d    = win_id;
                    cnt_d   = '0;
                    idle_d  = '0;
                end
            end
            ST_XFER: begin
                if (g_wr && fifo_full_i) begin
                    ovf_d = 1'b1;
                end else if (g_wr) begin
                    wr_d   = 1'b1;
                    msg_d  = g_byte;
                    cnt_d  = sat_inc(cnt_q);
                    idle_d = '0;
                    if (g_end) begin
                        end_d   = 1'b1;
                        len_d   = cnt_d;
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        last_d  = cur_idx;
                    end
                end else if (!fifo_full_i) begin
                    // Stalled cycles are excluded so backpressure never causes an abort.
                    if (idle_q == TO_W'(TIMEOUT - 1)) begin
                        abort_d = 1'b1;
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        last_d  = cur_idx;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + TO_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            id_q    <= '0;
            wr_q    <= 1'b0;
            msg_q   <= '0;
            end_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            idle_q  <= '0;
            abort_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            id_q    <= id_d;
            wr_q    <= wr_d;
            msg_q   <= msg_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idle_q  <= idle_d;
            abort_q <= abort_d;
            ovf_q   <= ovf_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign fifo_full_o  = ~gnt_q | {NUM_REQ{fifo_full_i}};
    assign fifo_write_o = wr_q;
    assign message_o    = msg_q;
    assign end_o        = end_q;
    assign id_o         = id_q;
    assign msg_len_o    = len_q;
    assign abort_o      = abort_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_fix_tx_arbiter.sv
// Directed bench for fix_tx_arbiter with two requesters and TIMEOUT=64.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_fix_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_i;
    logic [1:0]  fifo_write_i;
    logic [15:0] message_i;
    logic [1:0]  end_i;
    logic [3:0]  id_i;
    logic        fifo_full_i;
    logic [1:0]  gnt_o;
    logic [1:0]  fifo_full_o;
    logic        fifo_write_o;
    logic [7:0]  message_o;
    logic        end_o;
    logic [1:0]  id_o;
    logic [15:0] msg_len_o;
    logic        abort_o;
    logic        overflow_o;

    int errors    = 0;
    int checks    = 0;
    int abort_cnt = 0;
    int end_cnt   = 0;

    always #5 clk = ~clk;

    fix_tx_arbiter #(.NUM_REQ(2), .TIMEOUT(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .fifo_write_i (fifo_write_i),
        .message_i    (message_i),
        .end_i        (end_i),
        .id_i         (id_i),
        .fifo_full_i  (fifo_full_i),
        .gnt_o        (gnt_o),
        .fifo_full_o  (fifo_full_o),
        .fifo_write_o (fifo_write_o),
        .message_o    (message_o),
        .end_o        (end_o),
        .id_o         (id_o),
        .msg_len_o    (msg_len_o),
        .abort_o      (abort_o),
        .overflow_o   (overflow_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (abort_o) abort_cnt++;
        if (end_o) end_cnt++;
    endtask

    task automatic drive(input int k, input logic [7:0] b, input logic e);
        message_i    = '0;
        fifo_write_i = (k == 0) ? 2'b01 : 2'b10;
        end_i        = e ? fifo_write_i : 2'b00;
        if (k == 0) message_i[7:0] = b;
        else        message_i[15:8] = b;
    endtask

    task automatic idle_in();
        fifo_write_i = '0;
        end_i        = '0;
        message_i    = '0;
    endtask

    logic [7:0] t1_bytes [5] = '{8'h38, 8'h3D, 8'h46, 8'h49, 8'h58};
    int n;
    int ab0;
    int e0;

    initial begin
        rst         = 1'b0;
        req_i       = '0;
        fifo_full_i = 1'b0;
        id_i        = 4'b01_10;
        idle_in();
        repeat (2) @(posedge clk);
        #1;

        check("rst_gnt",      32'(gnt_o), 0);
        check("rst_full_o",   32'(fifo_full_o), 'h3);
        check("rst_wr",       32'(fifo_write_o), 0);
        check("rst_end",      32'(end_o), 0);
        check("rst_abort",    32'(abort_o), 0);
        check("rst_overflow", 32'(overflow_o), 0);
        check("rst_len",      32'(msg_len_o), 0);
        check("rst_id",       32'(id_o), 0);
        rst = 1'b1;

        // Single request, five bytes.
        tick();
        check("idle_no_req_gnt", 32'(gnt_o), 0);
        req_i = 2'b01;
        tick();
        check("t1_gnt",    32'(gnt_o), 'h1);
        check("t1_id",     32'(id_o), 'h2);
        check("t1_full_o", 32'(fifo_full_o), 'h2);
        for (int i = 0; i < 5; i++) begin
            drive(0, t1_bytes[i], i == 4);
            tick();
            check("t1_wr",  32'(fifo_write_o), 1);
            check("t1_msg", 32'(message_o), 32'(t1_bytes[i]));
            check("t1_end", 32'(end_o), (i == 4) ? 1 : 0);
        end
        check("t1_len",      32'(msg_len_o), 5);
        check("t1_gnt_drop", 32'(gnt_o), 0);
        idle_in();
        req_i = 2'b00;
        tick();
        check("t1_quiet_wr",  32'(fifo_write_o), 0);
        check("t1_quiet_end", 32'(end_o), 0);

        // Simultaneous requests from reset alternate 0, 1, 0.
        rst = 1'b0;
        tick();
        rst   = 1'b1;
        req_i = 2'b11;
        tick();
        check("t2_first_gnt", 32'(gnt_o), 'h1);
        fifo_write_i = 2'b10;
        end_i        = 2'b10;
        message_i    = 16'hCC00;
        tick();
        check("t2_nongrant_wr",  32'(fifo_write_o), 0);
        check("t2_nongrant_end", 32'(end_o), 0);
        check("t2_nongrant_gnt", 32'(gnt_o), 'h1);
        drive(0, 8'hAA, 1'b1);
        tick();
        check("t2_msg0", 32'(message_o), 'hAA);
        check("t2_end0", 32'(end_o), 1);
        check("t2_len0", 32'(msg_len_o), 1);
        check("t2_drop0", 32'(gnt_o), 0);
        idle_in();
        tick();
        check("t2_second_gnt", 32'(gnt_o), 'h2);
        check("t2_second_id",  32'(id_o), 'h1);
        drive(1, 8'hBB, 1'b1);
        tick();
        check("t2_msg1", 32'(message_o), 'hBB);
        check("t2_end1", 32'(end_o), 1);
        idle_in();
        tick();
        check("t2_third_gnt", 32'(gnt_o), 'h1);
        drive(0, 8'hCC, 1'b1);
        tick();
        req_i = 2'b00;
        idle_in();
        tick();

        // Backpressure mid-message must not count toward the timeout.
        req_i = 2'b01;
        tick();
        check("t3_gnt", 32'(gnt_o), 'h1);
        drive(0, 8'h11, 1'b0);
        tick();
        check("t3_msg_a", 32'(message_o), 'h11);
        idle_in();
        ab0 = abort_cnt;
        repeat (60) tick();
        fifo_full_i = 1'b1;
        tick();
        check("t3_full_o", 32'(fifo_full_o), 'h3);
        repeat (9) tick();
        check("t3_full_wr", 32'(fifo_write_o), 0);
        fifo_full_i = 1'b0;
        repeat (3) tick();
        drive(0, 8'h22, 1'b1);
        tick();
        check("t3_msg_b",   32'(message_o), 'h22);
        check("t3_end",     32'(end_o), 1);
        check("t3_len",     32'(msg_len_o), 2);
        check("t3_noabort", 32'(abort_cnt - ab0), 0);
        req_i = 2'b00;
        idle_in();
        tick();

        // Requester 1 stalls after three bytes (one dropped while full).
        req_i = 2'b11;
        tick();
        check("t4_gnt", 32'(gnt_o), 'h2);
        check("t4_id",  32'(id_o), 'h1);
        drive(1, 8'h01, 1'b0);
        tick();
        drive(1, 8'h02, 1'b0);
        tick();
        fifo_full_i = 1'b1;
        drive(1, 8'hEE, 1'b0);
        tick();
        check("t4_drop_wr",  32'(fifo_write_o), 0);
        check("t4_overflow", 32'(overflow_o), 1);
        fifo_full_i = 1'b0;
        drive(1, 8'h03, 1'b0);
        tick();
        check("t4_last_wr",  32'(fifo_write_o), 1);
        check("t4_last_msg", 32'(message_o), 'h03);
        idle_in();
        req_i = 2'b01;
        e0 = end_cnt;
        n  = 0;
        while (!abort_o && n < 200) begin
            tick();
            n++;
        end
        check("t4_abort_delay", 32'(n), 64);
        check("t4_no_end",      32'(end_cnt - e0), 0);
        check("t4_abort_gnt",   32'(gnt_o), 0);
        tick();
        check("t4_abort_pulse", 32'(abort_o), 0);
        check("t4_next_gnt",    32'(gnt_o), 'h1);
        check("t4_sticky_ovf",  32'(overflow_o), 1);

        // Reset in the middle of a message.
        drive(0, 8'h55, 1'b0);
        tick();
        check("t5_pre_wr", 32'(fifo_write_o), 1);
        ab0 = abort_cnt;
        e0  = end_cnt;
        rst = 1'b0;
        #1;
        check("t5_rst_gnt",  32'(gnt_o), 0);
        check("t5_rst_full", 32'(fifo_full_o), 'h3);
        check("t5_rst_wr",   32'(fifo_write_o), 0);
        check("t5_rst_ovf",  32'(overflow_o), 0);
        check("t5_rst_msg",  32'(message_o), 0);
        check("t5_rst_id",   32'(id_o), 0);
        idle_in();
        req_i = 2'b11;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("t5_regrant",   32'(gnt_o), 'h1);
        check("t5_silent",    32'(abort_cnt - ab0 + end_cnt - e0), 0);
        drive(0, 8'h66, 1'b1);
        tick();
        check("t5_len_fresh", 32'(msg_len_o), 1);
        req_i = 2'b00;
        idle_in();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
